// File: rtl/pipe_wb_delay_chain_pkg.sv
// Shared definitions for the writeback delay chain: default widths, entry
// layout width, and the forwarding-lookup result type.
package pipe_wb_delay_chain_pkg;

  // Default payload and register-address widths of the datapath.
  localparam int WB_DSIZE = 16;
  localparam int WB_ASIZE = 4;

  // Entry layout, MSB first: {valid, wen, is_load, rdy, waddr, data}.
  localparam int WB_FLAG_W = 4;

  // Width of one packed chain entry for a given payload/address width.
  function automatic int wb_entry_width(input int dsize, input int asize);
    return WB_FLAG_W + asize + dsize;
  endfunction

  // Outcome of a forwarding query against the chain.
  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_HIT    = 2'd1,
    FWD_HAZARD = 2'd2
  } fwd_result_e;

endpackage

// File: rtl/pipe_wb_delay_chain_stage.sv
// One register stage of the writeback chain. Holds on stall, clears on kill,
// and optionally replaces a pending load's payload with memory read data.
module pipe_wb_stage
  import pipe_wb_delay_chain_pkg::*;
#(
  parameter  int DSIZE = WB_DSIZE,
  parameter  int ASIZE = WB_ASIZE,
  localparam int EW    = wb_entry_width(DSIZE, ASIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             kill,
  input  logic             merge_en,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic [EW-1:0]    d_entry,
  output logic [EW-1:0]    q_entry
);

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             is_load;
    logic             rdy;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] data;
  } entry_t;

  entry_t d;
  entry_t d_next;
  entry_t q;

  assign d = d_entry;

  // Merge memory data into a not-yet-ready load as it enters this stage.
  always_comb begin
    // NOTE: default assignment first so every path drives d_next; no latch.
    d_next = d;
    if (merge_en && d.valid && d.is_load && !d.rdy) begin
      d_next.data = mem_rdata;
      d_next.rdy  = 1'b1;
    end
  end

  // Stage register: reset/kill clear the entry, stall holds it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every stage samples its neighbour's old value.
    if (rst) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (!stall) begin
      q <= d_next;
    end
  end

  assign q_entry = q;

endmodule

// File: rtl/pipe_wb_delay_chain.sv
// Writeback delay line between EXE_MEM and MEM_WB: DEPTH valid-tagged stages
// with stall, partial flush, load-data merge, forwarding and hazard lookup.
module pipe_wb_delay_chain
  import pipe_wb_delay_chain_pkg::*;
#(
  parameter  int DSIZE       = WB_DSIZE,
  parameter  int ASIZE       = WB_ASIZE,
  parameter  int DEPTH       = 3,
  parameter  int LOAD_STAGE  = 1,
  parameter  int FLUSH_DEPTH = 1,
  parameter  bit ZERO_REG    = 1'b0,
  localparam int OW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  input  logic [ASIZE-1:0] in_waddr,
  input  logic             in_wen,
  input  logic             in_is_load,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic             stall,
  input  logic             flush,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [DSIZE-1:0] fwd_data1,
  output logic [DSIZE-1:0] fwd_data2,
  output logic             hazard,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [ASIZE-1:0] out_waddr,
  output logic             out_wen,
  output logic [OW-1:0]    occupancy
);

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             is_load;
    logic             rdy;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] data;
  } entry_t;

  typedef struct packed {
    fwd_result_e      kind;
    logic [DSIZE-1:0] data;
  } fwd_t;

  entry_t                in_entry;
  entry_t [DEPTH-1:0]    stage_d;
  entry_t [DEPTH-1:0]    stage_q;
  fwd_t                  fwd1;
  fwd_t                  fwd2;

  // New entry; a flushing cycle never captures the incoming instruction.
  always_comb begin
    in_entry         = '0;
    in_entry.valid   = in_valid & ~flush;
    in_entry.wen     = in_wen;
    in_entry.is_load = in_is_load;
    in_entry.rdy     = ~in_is_load;
    in_entry.waddr   = in_waddr;
    in_entry.data    = in_data;
  end

  // Shift path: stage 0 takes the input, every other stage its younger neighbour.
  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit FLUSHABLE = (i < FLUSH_DEPTH);
    localparam bit MERGE     = (i == LOAD_STAGE);

    pipe_wb_stage #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .kill      (flush & FLUSHABLE),
      .merge_en  (MERGE),
      .mem_rdata (mem_rdata),
      .d_entry   (stage_d[i]),
      .q_entry   (stage_q[i])
    );
  end

  // Youngest matching writer wins; an unready winner blocks older stages.
  function automatic fwd_t fwd_lookup(input logic [ASIZE-1:0] raddr,
                                      input entry_t [DEPTH-1:0] st);
    fwd_t r;
    logic done;
    r    = '{kind: FWD_NONE, data: '0};
    done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!done && st[i].valid && st[i].wen && st[i].waddr == raddr) begin
        done = 1'b1;
        if (st[i].rdy) begin
          r.kind = FWD_HIT;
          r.data = st[i].data;
        end else begin
          r.kind = FWD_HAZARD;
        end
      end
    end
    if (ZERO_REG && raddr == '0) begin
      r = '{kind: FWD_NONE, data: '0};
    end
    return r;
  endfunction

  // Forwarding queries for both register-read ports.
  always_comb begin
    fwd1 = fwd_lookup(raddr1, stage_q);
    fwd2 = fwd_lookup(raddr2, stage_q);
  end

  assign fwd_hit1  = (fwd1.kind == FWD_HIT);
  assign fwd_hit2  = (fwd2.kind == FWD_HIT);
  assign fwd_data1 = fwd_hit1 ? fwd1.data : '0;
  assign fwd_data2 = fwd_hit2 ? fwd2.data : '0;
  assign hazard    = (fwd1.kind == FWD_HAZARD) | (fwd2.kind == FWD_HAZARD);

  // Number of live entries in the chain.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(stage_q[i].valid);
    end
  end

  // Oldest stage drives the regfile; the commit is dropped on stall or reset.
  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_data  = stage_q[DEPTH-1].data;
  assign out_waddr = stage_q[DEPTH-1].waddr;
  assign out_wen   = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].wen & ~stall & ~rst;

endmodule
